// File: rtl/ascii_uart_tx_if.sv
// Handshake and serial-line bundle between an ASCII word producer and the UART transmitter.
// The master drives the word and start; the slave (transmitter) returns busy, done and tx.
interface ascii_uart_tx_if #(
    parameter int unsigned NUM_CHARS = 4
);
    logic [NUM_CHARS*8-1:0] ascii_in;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   tx;

    modport master (
        output ascii_in,
        output start,
        input  busy,
        input  done,
        input  tx
    );

    modport slave (
        input  ascii_in,
        input  start,
        output busy,
        output done,
        output tx
    );
endinterface

// File: rtl/ascii_uart_tx.sv
// Serialises a latched word of ASCII characters, most-significant character first, over 8N1 UART,
// optionally followed by CR LF so every captured word appears as its own terminal line.
module ascii_uart_tx #(
    parameter int unsigned NUM_CHARS    = 4,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned APPEND_CRLF  = 1
) (
    input  logic           clk,
    input  logic           rst,
    ascii_uart_tx_if.slave bus
);
    localparam int unsigned TOTAL = NUM_CHARS + 2 * APPEND_CRLF;
    localparam int unsigned W_BUF = NUM_CHARS * 8;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        NEXT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W_BUF-1:0]   buf_q, buf_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end_c;

    // Character idx of the transmit sequence: word bytes MSB first, then CR, then LF.
    function automatic logic [7:0] pick(input logic [W_BUF-1:0] word, input logic [IDX_W-1:0] idx);
        logic [7:0] c;
        c = 8'h0A;
        for (int k = 0; k < int'(NUM_CHARS); k++) begin
            if (idx == IDX_W'(k)) begin
                c = word[W_BUF-1-8*k -: 8];
            end
        end
        if (idx == IDX_W'(NUM_CHARS)) begin
            c = 8'h0D;
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // tx_d is the line level for the state being entered, so tx changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bit_end_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (bus.start) begin
                    buf_d   = bus.ascii_in;
                    idx_d   = '0;
                    shift_d = pick(bus.ascii_in, '0);
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end_c) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_end_c) begin
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NEXT: begin
                cnt_d = '0;
                if (idx_q < IDX_W'(TOTAL - 1)) begin
                    idx_d   = idx_q + IDX_W'(1);
                    shift_d = pick(buf_q, idx_q + IDX_W'(1));
                    tx_d    = 1'b0;
                    state_d = START;
                end else begin
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_ascii_uart_tx.sv
// Bench for ascii_uart_tx: two instances (no suffix / CR LF suffix) share one stimulus and are
// checked every cycle against a timeline model, plus literal byte and latency expectations.
module tb_ascii_uart_tx;
    localparam int CB = 4;
    localparam int NC = 4;
    localparam int CHAR_CYC = 10 * CB + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ascii = '0;
    logic [1:0]  start_v = '0;
    logic [1:0]  tx_w, busy_w, done_w;

    always #5 clk = ~clk;

    ascii_uart_tx_if #(.NUM_CHARS(NC)) bus0 ();
    ascii_uart_tx_if #(.NUM_CHARS(NC)) bus1 ();

    assign bus0.ascii_in = ascii;
    assign bus0.start    = start_v[0];
    assign bus1.ascii_in = ascii;
    assign bus1.start    = start_v[1];
    assign tx_w   = {bus1.tx, bus0.tx};
    assign busy_w = {bus1.busy, bus0.busy};
    assign done_w = {bus1.done, bus0.done};

    ascii_uart_tx #(.NUM_CHARS(NC), .CLKS_PER_BIT(CB), .APPEND_CRLF(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );
    ascii_uart_tx #(.NUM_CHARS(NC), .CLKS_PER_BIT(CB), .APPEND_CRLF(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int launch_e = 0;

    // ---------------- timeline model ----------------
    bit         act [2];
    int         s_e [2];
    logic [7:0] ch  [2][6];

    function automatic int dur(input int i);
        return ((i == 0) ? 4 : 6) * CHAR_CYC;
    endfunction

    function automatic bit mbusy(input int i, input int c);
        return act[i] && c >= s_e[i] && c < s_e[i] + dur(i);
    endfunction

    // {tx, busy, done} expected in the cycle following edge c
    function automatic logic [2:0] model_exp(input int i, input int c);
        int off, k, r;
        logic t;
        if (!act[i] || c < s_e[i]) return 3'b100;
        off = c - s_e[i];
        if (off < dur(i)) begin
            k = off / CHAR_CYC;
            r = off % CHAR_CYC;
            if (r < CB) t = 1'b0;
            else if (r < 9 * CB) t = ch[i][k][(r - CB) / CB];
            else t = 1'b1;
            return {t, 2'b10};
        end
        if (off == dur(i)) return 3'b101;
        return 3'b100;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                act[i] = 1'b0;
            end else if (start_v[i] && !mbusy(i, cyc - 1)) begin
                act[i] = 1'b1;
                s_e[i] = cyc;
                for (int k = 0; k < NC; k++) ch[i][k] = ascii[31-8*k -: 8];
                ch[i][4] = 8'h0D;
                ch[i][5] = 8'h0A;
            end
        end
    end

    task automatic check(input string name, input int i, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a === e) passes++;
        else $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, i, cyc, a, e);
    endtask

    // ---------------- per-cycle compare and line decoder ----------------
    int         done_cnt   [2];
    int         done_first [2];
    int         done_last  [2];
    bit         dact [2];
    int         dcnt [2];
    logic [7:0] dsh  [2];
    logic [7:0] rxq0 [$];
    logic [7:0] rxq1 [$];

    always @(negedge clk) begin : cmp
        logic [2:0] e;
        if (cyc >= 1) begin
            for (int i = 0; i < 2; i++) begin
                e = model_exp(i, cyc);
                check("tx", i, 32'(tx_w[i]), 32'(e[2]));
                check("busy", i, 32'(busy_w[i]), 32'(e[1]));
                check("done", i, 32'(done_w[i]), 32'(e[0]));
                if (done_w[i] === 1'b1) begin
                    done_cnt[i]++;
                    done_last[i] = cyc;
                    if (done_first[i] < 0) done_first[i] = cyc;
                end
                if (rst) begin
                    dact[i] = 1'b0;
                end else if (!dact[i]) begin
                    if (tx_w[i] === 1'b0) begin
                        dact[i] = 1'b1;
                        dcnt[i] = 0;
                    end
                end else begin
                    dcnt[i]++;
                    if (dcnt[i] >= CB && dcnt[i] < 9 * CB && dcnt[i] % CB == CB / 2)
                        dsh[i] = {tx_w[i], dsh[i][7:1]};
                    if (dcnt[i] == 9 * CB + CB / 2) begin
                        check("stop_bit", i, 32'(tx_w[i]), 32'd1);
                        if (i == 0) rxq0.push_back(dsh[i]);
                        else rxq1.push_back(dsh[i]);
                        dact[i] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] expq [$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 2; i++) begin
            done_cnt[i]   = 0;
            done_first[i] = -1;
            done_last[i]  = -1;
        end
        rxq0.delete();
        rxq1.delete();
    endtask

    task automatic launch(input logic [1:0] which, input logic [31:0] w);
        ascii    = w;
        start_v  = which;
        launch_e = cyc + 1;
        @(negedge clk);
        start_v  = 2'b00;
    endtask

    task automatic exp_word(input int i, input logic [31:0] w);
        for (int k = 0; k < NC; k++) expq.push_back(w[31-8*k -: 8]);
        if (i == 1) begin
            expq.push_back(8'h0D);
            expq.push_back(8'h0A);
        end
    endtask

    task automatic check_rx(input int i, input string tag);
        logic [7:0] q [$];
        q = (i == 0) ? rxq0 : rxq1;
        check({tag, "_nbytes"}, i, 32'(q.size()), 32'(expq.size()));
        for (int k = 0; k < expq.size(); k++) begin
            if (k < q.size()) check({tag, "_byte"}, i, 32'(q[k]), 32'(expq[k]));
        end
    endtask

    task automatic single_word(input logic [31:0] w, input string tag);
        clear_obs();
        launch(2'b11, w);
        tick(260);
        for (int i = 0; i < 2; i++) begin
            expq.delete();
            exp_word(i, w);
            check_rx(i, tag);
            check({tag, "_done_cnt"}, i, 32'(done_cnt[i]), 32'd1);
            check({tag, "_latency"}, i, 32'(done_first[i] - launch_e), (i == 0) ? 32'd164 : 32'd246);
        end
    endtask

    initial begin : stim
        bit re [2];
        clear_obs();
        tick(3);
        rst = 1'b0;

        // idle line after reset
        clear_obs();
        tick(1000);
        for (int i = 0; i < 2; i++) begin
            check("idle_done_cnt", i, 32'(done_cnt[i]), 32'd0);
            check("idle_rx", i, (i == 0) ? 32'(rxq0.size()) : 32'(rxq1.size()), 32'd0);
        end

        single_word(32'h31323334, "w1234");
        single_word(32'h41424344, "wABCD");

        // start and new data ignored while busy
        clear_obs();
        launch(2'b11, 32'h46304531);
        tick(50);
        ascii   = 32'hFFFF_FFFF;
        start_v = 2'b11;
        tick(1);
        start_v = 2'b00;
        tick(260);
        for (int i = 0; i < 2; i++) begin
            expq.delete();
            exp_word(i, 32'h46304531);
            check_rx(i, "ignore");
            check("ignore_done_cnt", i, 32'(done_cnt[i]), 32'd1);
        end

        // reset during data bit 3 of character 1
        clear_obs();
        launch(2'b11, 32'h31323334);
        tick(58);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_tx", i, 32'(tx_w[i]), 32'd1);
            check("rst_busy", i, 32'(busy_w[i]), 32'd0);
        end
        tick(1);
        rst = 1'b0;
        tick(60);
        for (int i = 0; i < 2; i++) begin
            check("rst_done_cnt", i, 32'(done_cnt[i]), 32'd0);
            expq.delete();
            expq.push_back(8'h31);
            check_rx(i, "rst_partial");
        end
        single_word(32'h31323334, "after_rst");

        // back-to-back: restart in each instance's done cycle
        clear_obs();
        re[0] = 1'b0;
        re[1] = 1'b0;
        launch(2'b11, 32'h31323334);
        repeat (560) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                start_v[i] = (done_w[i] === 1'b1) && !re[i];
                if (start_v[i]) begin
                    re[i] = 1'b1;
                    ascii = 32'h35363738;
                end
            end
        end
        start_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            expq.delete();
            exp_word(i, 32'h31323334);
            exp_word(i, 32'h35363738);
            check_rx(i, "b2b");
            check("b2b_done_cnt", i, 32'(done_cnt[i]), 32'd2);
            check("b2b_latency", i, 32'(done_last[i] - launch_e), (i == 0) ? 32'd329 : 32'd493);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
